muldiv_unit: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit executing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the single-cycle ALU in the EX stage.
- Iterative shift-add multiplier and restoring divider process UNROLL bits per cycle.
- Valid/ready handshakes on both sides, a pass-through tag, and flush for pipeline kills.
- Produces N/Z flags in the same style as the ALU.

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier and restoring divider
// retiring UNROLL bits per cycle, with valid/ready handshakes, a pass-through tag and flush.
module muldiv_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             aN,
  output logic             aZ,
  output logic             busy
);

  localparam int unsigned Steps = WIDTH / UNROLL;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  // Mul: hi/lo = running product, lo starts as the multiplier, opnd = multiplicand.
  // Div: hi = partial remainder, lo = dividend shifting out / quotient shifting in, opnd = divisor.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;

  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign a_neg    = a_signed & a_in[WIDTH-1];
  assign b_neg    = b_signed & b_in[WIDTH-1];
  assign a_mag    = a_neg ? -a_in : a_in;
  assign b_mag    = b_neg ? -b_in : b_in;
  assign div_zero = op[2] && (b_in == '0);
  assign div_ovf  = op[2] && !op[0] && (a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (b_in == '1);

  // UNROLL iterations of the active algorithm, chained combinationally.
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   sum, rs;
  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    sum     = '0;
    rs      = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (op_q[2]) begin
        rs      = {step_hi, step_lo[WIDTH-1]};
        step_lo = step_lo << 1;
        if (rs >= {1'b0, opnd_q}) begin
          rs         = rs - {1'b0, opnd_q};
          step_lo[0] = 1'b1;
        end
        step_hi = rs[WIDTH-1:0];
      end else begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd_q} : '0);
        step_lo = {sum[0], step_lo[WIDTH-1:1]};
        step_hi = sum[WIDTH:1];
      end
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_result;
  always_comb begin
    prod = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    if (!op_q[2]) begin
      fix_result = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (!op_q[1]) begin
      fix_result = neg_res_q ? -lo_q : lo_q;
    end else begin
      fix_result = neg_rem_q ? -hi_q : hi_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    tag_out_d = tag_out_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          op_d      = op;
          tag_d     = tag_in;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          hi_d      = '0;
          lo_d      = op[2] ? a_mag : b_mag;
          opnd_d    = op[2] ? b_mag : a_mag;
          if (div_zero) begin
            state_d   = StDone;
            result_d  = op[1] ? a_in : '1;
            tag_out_d = tag_in;
          end else if (div_ovf) begin
            state_d   = StDone;
            result_d  = op[1] ? '0 : a_in;
            tag_out_d = tag_in;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end
      StFix: begin
        result_d  = fix_result;
        tag_out_d = tag_q;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      tag_out_q <= tag_out_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !flush;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign tag_out   = tag_out_q;
  assign aN        = result_q[WIDTH-1];
  assign aZ        = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a_in, b_in, result;
  logic [4:0]  tag_in, tag_out;
  logic        aN, aZ, busy;

  muldiv_unit #(.WIDTH(32), .UNROLL(1), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a_in(a_in), .b_in(b_in), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .tag_out(tag_out), .aN(aN), .aZ(aZ), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        exp_pending = 1'b0;
  logic [31:0] exp_result = '0;
  logic [4:0]  exp_tag = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] res;
    longint      sa, sb;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    p   = '0;
    res = '0;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); res = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
      3'd4: res = (b == 0) ? 32'hffff_ffff : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: res = (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  // Compare process: whenever a result is presented it must match the pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check("spurious_out_valid", {31'b0, exp_pending}, 32'd1);
      if (exp_pending) begin
        check("result", result, exp_result);
        check("tag_out", {27'b0, tag_out}, {27'b0, exp_tag});
        check("aN", {31'b0, aN}, {31'b0, exp_result[31]});
        check("aZ", {31'b0, aZ}, {31'b0, exp_result == 0});
        check("in_ready_done", {31'b0, in_ready}, 32'd0);
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] exp, input int hold);
    int n, lat;
    lat = (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hffff_ffff))) ? 1 : 34;
    @(posedge clk); #1;
    op = o; a_in = a; b_in = b; tag_in = t; in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_pending = 1'b1; exp_result = exp; exp_tag = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("latency", n, lat);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_pending = 1'b0;
    @(negedge clk);
    check("out_valid_drop", {31'b0, out_valid}, 32'd0);
    check("in_ready_after", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag_out", {27'b0, tag_out}, 32'd0);
    check("rst_aN", {31'b0, aN}, 32'd0);
    check("rst_aZ", {31'b0, aZ}, 32'd1);
  endtask

  // Starts a MUL, lets it run 10 BUSY cycles, then kills it with flush or rst.
  task automatic kill_mid_op(input logic use_rst);
    @(posedge clk); #1;
    op = 3'd0; a_in = 32'd6; b_in = 32'd7; tag_in = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    // A divide-by-zero here would complete next cycle if it were wrongly accepted.
    op = 3'd5; a_in = 32'd5; b_in = 32'd0; in_valid = 1'b1;
    if (use_rst) rst = 1'b1;
    else begin
      flush = 1'b1;
      #1 check("in_ready_flush", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    flush = 1'b0; rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    if (use_rst) check_reset_values();
    else begin
      check("flush_busy", {31'b0, busy}, 32'd0);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    end
    repeat (40) @(negedge clk);
    check("no_out_after_kill", {31'b0, out_valid}, 32'd0);
  endtask

  logic [2:0]  d_op [12] = '{3, 0, 1, 2, 4, 6, 5, 7, 5, 7, 4, 6};
  logic [31:0] d_a  [12] = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                             32'hfffffff9, 32'hfffffff9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h80000000, 32'h80000000};
  logic [31:0] d_b  [12] = '{32'hffffffff, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'd0, 32'hffffffff, 32'hffffffff};
  logic [31:0] d_exp[12] = '{32'hfffffffe, 32'hfffffffd, 32'hffffffff, 32'hffffffff,
                             32'hfffffffd, 32'hffffffff, 32'd14, 32'd2, 32'hffffffff, 32'd5,
                             32'h80000000, 32'd0};

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a_in = '0; b_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // First op holds out_ready low for 10 cycles in DONE.
    for (int i = 0; i < 12; i++) begin
      check("model_pin", model(d_op[i], d_a[i], d_b[i]), d_exp[i]);
      do_op(d_op[i], d_a[i], d_b[i], (i == 0) ? 5'd7 : 5'(i), d_exp[i], (i == 0) ? 10 : 0);
    end

    kill_mid_op(1'b0);
    do_op(3'd0, 32'd6, 32'd7, 5'd9, 32'd42, 0);
    kill_mid_op(1'b1);
    do_op(3'd0, 32'd6, 32'd7, 5'd10, 32'd42, 0);

    for (int i = 0; i < 150; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hffff_ffff; end
      else if (sel == 2) begin
        a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9));
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      do_op(o, a, b, 5'($urandom), model(o, a, b), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
